semafor_monitor: RTL
====================

Name: semafor_monitor

Overview:
- Receive-side checker for the intersection lamp bus driven by the traffic-light generator: consumes the 14 lamp signals (4 car directions × verde/galben/rosu, pedestrian verde/rosu).
- Verifies encoding, mutual exclusion, lamp sequence and phase durations.
- Latches the first violation as a sticky fault and reports completed rounds.
- Sits beside the generator; in the optional build it can feed a service request back to the controller.

Parameters:
- FACTOR_DIV, 10, clock cycles per second; matches the generator's divider.
- MAX_VERDE_SEC, 30, longest legal continuous car green, in seconds.
- MIN_GALBEN_SEC, 2, shortest legal yellow, in seconds.
- MAX_GALBEN_SEC, 5, longest legal yellow, in seconds.
- CNT_W, 10, width of the per-direction cycle counters; must hold MAX_VERDE_SEC*FACTOR_DIV+1.

Ports:
- clk_i  in  1  system clock
- reset  in  1  synchronous, active-high reset
- service_i  in  1  controller in service mode; checks suspended
- verde_nord, galben_nord, rosu_nord  in  1 each  north lamps
- verde_sud, galben_sud, rosu_sud  in  1 each  south lamps
- verde_est, galben_est, rosu_est  in  1 each  east lamps
- verde_vest, galben_vest, rosu_vest  in  1 each  west lamps
- verde_pietoni, rosu_pietoni  in  1 each  pedestrian lamps
- fault_o  out  1  sticky fault flag
- fault_code_o  out  3  first violation code
- fault_dir_o  out  3  direction of the violation
- cycle_done_o  out  1  one-cycle pulse per completed round
- service_req_o  out  1  service request (optional feature)

Behaviour:
- Single clock domain; one clock, synchronous active-high reset on clk_i.
- Reset values: all outputs 0; state WAIT_RED; all counters 0; previous-lamp registers = all rosu; round bits 0.
- Direction index for fault_dir_o: 0 nord, 1 sud, 2 est, 3 vest, 4 pietoni, 7 multi/none.
- State WAIT_RED:
  - No checks.
  - Go to RUN on the first edge sampling every car direction rosu and the pedestrian lamp rosu.
- State RUN: checks evaluated each edge on current inputs plus previous-lamp registers.
  - Code 1 ILLEGAL_LAMP: a car direction not exactly one-hot over {verde, galben, rosu}, or pedestrian not exactly one of {verde, rosu}.
  - Code 2 CONFLICT: more than one car direction non-rosu, or verde_pietoni with any car direction non-rosu. fault_dir = 7.
  - Code 3 VERDE_TIMEOUT: a car verde held for more than MAX_VERDE_SEC*FACTOR_DIV consecutive cycles. Fires on the first cycle beyond the limit.
  - Code 4 GALBEN_TIME: on galben→rosu, the galben run length in cycles lies outside [MIN_GALBEN_SEC*FACTOR_DIV, MAX_GALBEN_SEC*FACTOR_DIV]. Also fires once galben exceeds the max while still lit.
  - Code 5 SEQUENCE: a car transition other than rosu→verde, verde→galben or galben→rosu.
- Per-direction counter:
  - Clears to 1 on any lamp change; otherwise increments.
  - Saturates at 2^CNT_W−1 and never wraps.
- Fault capture:
  - On a violation: fault_o, fault_code_o and fault_dir_o are registered at the same edge the violating inputs are sampled, so they are visible from the next cycle.
  - State goes to FAULT.
  - Simultaneous violations: lowest code wins; within a code, lowest direction index wins.
- State FAULT: outputs frozen until reset; service_i ignored.
- State SERVICE:
  - Entered from WAIT_RED or RUN whenever service_i = 1 at an edge.
  - Counters and round bits cleared; no checks.
  - On service_i = 0, go to WAIT_RED.
- Round tracking:
  - Each car direction sets its round bit on a verde→galben transition.
  - When all 4 bits are set, cycle_done_o pulses high for exactly one cycle and the bits clear in that same cycle.
  - A transition coincident with the clear sets its bit for the next round.
- Reset mid-operation overrides everything, including FAULT.

Optional Feature:
- Macro SEMAFOR_MON_SERVICE_REQ_EN.
- Defined: service_req_o = fault_o (registered, same timing), intended to drive the controller's service_i.
- Undefined: service_req_o tied to 0; no other change.

Test Plan:
- Reset, all-red 2 cycles, then a legal round with FACTOR_DIV = 10: nord 17 s green, 3 s yellow, then sud 22 s, est 19 s, vest 20 s, pedestrian 12 s → fault_o stays 0. cycle_done_o pulses once, the cycle after vest goes galben.
- In RUN, verde_nord and verde_est both 1 for one cycle → fault_o = 1, fault_code_o = 2, fault_dir_o = 7. Values hold after inputs return legal.
- verde_sud held 301 cycles → fault_code_o = 3, fault_dir_o = 1 on cycle 301, not on cycle 300.
- est goes verde→rosu directly → code 5, dir 2. galben_vest lasting 15 cycles → code 4, dir 3.
- service_i = 1 with illegal lamps (all galben), then service_i = 0 and all-red → no fault. A subsequent conflict is detected normally.
- Two violations in one cycle (nord galben+rosu together, plus pietoni verde during a car green) → code 1, dir 0. Under SEMAFOR_MON_SERVICE_REQ_EN, service_req_o = 1 in the same cycle as fault_o; without the macro it stays 0.

Source files
------------

// File: rtl/semafor_monitor.sv
// Receive-side checker for the intersection lamp bus: encoding, exclusion, sequence and phase timing.
// Optional build: define SEMAFOR_MON_SERVICE_REQ_EN to drive service_req_o from the sticky fault.
module semafor_monitor #(
  parameter int FACTOR_DIV     = 10,
  parameter int MAX_VERDE_SEC  = 30,
  parameter int MIN_GALBEN_SEC = 2,
  parameter int MAX_GALBEN_SEC = 5,
  parameter int CNT_W          = 10
) (
  input  logic       clk_i,
  input  logic       reset,
  input  logic       service_i,
  input  logic       verde_nord,
  input  logic       galben_nord,
  input  logic       rosu_nord,
  input  logic       verde_sud,
  input  logic       galben_sud,
  input  logic       rosu_sud,
  input  logic       verde_est,
  input  logic       galben_est,
  input  logic       rosu_est,
  input  logic       verde_vest,
  input  logic       galben_vest,
  input  logic       rosu_vest,
  input  logic       verde_pietoni,
  input  logic       rosu_pietoni,
  output logic       fault_o,
  output logic [2:0] fault_code_o,
  output logic [2:0] fault_dir_o,
  output logic       cycle_done_o,
  output logic       service_req_o
);

  typedef enum logic [1:0] {
    WAIT_RED = 2'd0,
    RUN      = 2'd1,
    FAULT    = 2'd2,
    SERVICE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] VERDE_LIM  = CNT_W'(MAX_VERDE_SEC * FACTOR_DIV);
  localparam logic [CNT_W-1:0] GALBEN_MIN = CNT_W'(MIN_GALBEN_SEC * FACTOR_DIV);
  localparam logic [CNT_W-1:0] GALBEN_MAX = CNT_W'(MAX_GALBEN_SEC * FACTOR_DIV);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

  // Lamp triples are packed {verde, galben, rosu}
  localparam logic [2:0] L_VERDE  = 3'b100;
  localparam logic [2:0] L_GALBEN = 3'b010;
  localparam logic [2:0] L_ROSU   = 3'b001;

  function automatic logic is_onehot3(input logic [2:0] l);
    return (l == L_VERDE) || (l == L_GALBEN) || (l == L_ROSU);
  endfunction

  function automatic logic [2:0] first_dir(input logic [4:0] f);
    casez (f)
      5'b????1: return 3'd0;
      5'b???10: return 3'd1;
      5'b??100: return 3'd2;
      5'b?1000: return 3'd3;
      5'b10000: return 3'd4;
      default:  return 3'd7;
    endcase
  endfunction

  state_t           state_r;
  logic [2:0]       prev_r [4];
  logic [CNT_W-1:0] cnt_r  [4];
  logic [3:0]       round_r;
  logic             fault_r;
  logic [2:0]       code_r;
  logic [2:0]       dir_r;
  logic             cycle_done_r;

  logic [2:0]       lamp_s    [4];
  logic [CNT_W-1:0] run_len_s [4];
  logic [4:0]       ill_s;
  logic [3:0]       nonred_s;
  logic [3:0]       vg_s;
  logic [3:0]       tmo_s;
  logic [3:0]       gal_s;
  logic [3:0]       seq_s;
  logic             conflict_s;
  logic             all_red_s;
  logic             viol_s;
  logic [2:0]       vcode_s;
  logic [2:0]       vdir_s;
  logic [3:0]       round_or_s;

  assign lamp_s[0] = {verde_nord, galben_nord, rosu_nord};
  assign lamp_s[1] = {verde_sud,  galben_sud,  rosu_sud};
  assign lamp_s[2] = {verde_est,  galben_est,  rosu_est};
  assign lamp_s[3] = {verde_vest, galben_vest, rosu_vest};

  // Per-direction run lengths and the five violation classes, then first-fault priority.
  always_comb begin
    ill_s      = 5'b0;
    nonred_s   = 4'b0;
    vg_s       = 4'b0;
    tmo_s      = 4'b0;
    gal_s      = 4'b0;
    seq_s      = 4'b0;
    for (int d = 0; d < 4; d++) begin
      run_len_s[d] = CNT_ONE;
      if (lamp_s[d] != prev_r[d]) begin
        run_len_s[d] = CNT_ONE;
      end else if (cnt_r[d] == CNT_SAT) begin
        run_len_s[d] = CNT_SAT;
      end else begin
        run_len_s[d] = cnt_r[d] + CNT_ONE;
      end
      ill_s[d]    = !is_onehot3(lamp_s[d]);
      nonred_s[d] = !lamp_s[d][0];
      vg_s[d]     = (prev_r[d] == L_VERDE) && (lamp_s[d] == L_GALBEN);
      tmo_s[d]    = (lamp_s[d] == L_VERDE) && (run_len_s[d] > VERDE_LIM);
      // A finished yellow is judged on the stored count; a live one only against the max
      gal_s[d]    = ((prev_r[d] == L_GALBEN) && (lamp_s[d] == L_ROSU) &&
                     ((cnt_r[d] < GALBEN_MIN) || (cnt_r[d] > GALBEN_MAX))) ||
                    ((lamp_s[d] == L_GALBEN) && (run_len_s[d] > GALBEN_MAX));
      seq_s[d]    = (lamp_s[d] != prev_r[d]) && is_onehot3(lamp_s[d]) &&
                    !(((prev_r[d] == L_ROSU) && (lamp_s[d] == L_VERDE)) || vg_s[d] ||
                      ((prev_r[d] == L_GALBEN) && (lamp_s[d] == L_ROSU)));
    end
    ill_s[4]   = !(verde_pietoni ^ rosu_pietoni);
    conflict_s = !$onehot0(nonred_s) || (verde_pietoni && (|nonred_s));
    all_red_s  = (lamp_s[0] == L_ROSU) && (lamp_s[1] == L_ROSU) && (lamp_s[2] == L_ROSU) &&
                 (lamp_s[3] == L_ROSU) && !verde_pietoni && rosu_pietoni;
    round_or_s = round_r | vg_s;

    viol_s  = 1'b0;
    vcode_s = 3'd0;
    vdir_s  = 3'd7;
    if (|ill_s) begin
      viol_s  = 1'b1;
      vcode_s = 3'd1;
      vdir_s  = first_dir(ill_s);
    end else if (conflict_s) begin
      viol_s  = 1'b1;
      vcode_s = 3'd2;
      vdir_s  = 3'd7;
    end else if (|tmo_s) begin
      viol_s  = 1'b1;
      vcode_s = 3'd3;
      vdir_s  = first_dir({1'b0, tmo_s});
    end else if (|gal_s) begin
      viol_s  = 1'b1;
      vcode_s = 3'd4;
      vdir_s  = first_dir({1'b0, gal_s});
    end else if (|seq_s) begin
      viol_s  = 1'b1;
      vcode_s = 3'd5;
      vdir_s  = first_dir({1'b0, seq_s});
    end else begin
      viol_s  = 1'b0;
      vcode_s = 3'd0;
      vdir_s  = 3'd7;
    end
  end

  // Monitor state machine, lamp history, counters, round tracking and sticky fault capture.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_r      <= WAIT_RED;
      fault_r      <= 1'b0;
      code_r       <= 3'd0;
      dir_r        <= 3'd0;
      cycle_done_r <= 1'b0;
      round_r      <= 4'b0;
      for (int d = 0; d < 4; d++) begin
        prev_r[d] <= L_ROSU;
        cnt_r[d]  <= CNT_ZERO;
      end
    end else begin
      case (state_r)
        WAIT_RED: begin
          cycle_done_r <= 1'b0;
          for (int d = 0; d < 4; d++) prev_r[d] <= lamp_s[d];
          if (service_i) begin
            state_r <= SERVICE;
            round_r <= 4'b0;
            for (int d = 0; d < 4; d++) cnt_r[d] <= CNT_ZERO;
          end else begin
            state_r <= all_red_s ? RUN : WAIT_RED;
            for (int d = 0; d < 4; d++) cnt_r[d] <= run_len_s[d];
          end
        end
        RUN: begin
          if (service_i) begin
            state_r      <= SERVICE;
            cycle_done_r <= 1'b0;
            round_r      <= 4'b0;
            for (int d = 0; d < 4; d++) begin
              prev_r[d] <= lamp_s[d];
              cnt_r[d]  <= CNT_ZERO;
            end
          end else if (viol_s) begin
            state_r      <= FAULT;
            fault_r      <= 1'b1;
            code_r       <= vcode_s;
            dir_r        <= vdir_s;
            cycle_done_r <= 1'b0;
          end else begin
            for (int d = 0; d < 4; d++) begin
              prev_r[d] <= lamp_s[d];
              cnt_r[d]  <= run_len_s[d];
            end
            // Completing round clears; a repeat hand-off at the same edge seeds the next round
            if (&round_or_s) begin
              cycle_done_r <= 1'b1;
              round_r      <= round_r & vg_s;
            end else begin
              cycle_done_r <= 1'b0;
              round_r      <= round_or_s;
            end
          end
        end
        SERVICE: begin
          cycle_done_r <= 1'b0;
          round_r      <= 4'b0;
          for (int d = 0; d < 4; d++) begin
            prev_r[d] <= lamp_s[d];
            cnt_r[d]  <= CNT_ZERO;
          end
          state_r <= service_i ? SERVICE : WAIT_RED;
        end
        FAULT: begin
          state_r <= FAULT;
        end
        default: begin
          state_r <= WAIT_RED;
        end
      endcase
    end
  end

  assign fault_o      = fault_r;
  assign fault_code_o = code_r;
  assign fault_dir_o  = dir_r;
  assign cycle_done_o = cycle_done_r;

`ifdef SEMAFOR_MON_SERVICE_REQ_EN
  assign service_req_o = fault_r;
`else
  assign service_req_o = 1'b0;
`endif

endmodule
